// File: rtl/dac_spi_out.sv
// Sample-rate pacer and 24-bit SPI write-frame serializer for a multi-channel DAC.
// Pops one PCM word per channel per tick, holds the last sample on underrun.
module dac_spi_out #(
  parameter int         CHANNEL    = 3,
  parameter int         SCLK_HALF  = 2,
  parameter int         CS_GAP     = 2,
  parameter logic [3:0] DAC_CMD    = 4'b0011,
  parameter bit         OFFSET_BIN = 1'b1
) (
  input  logic                   pcm_clk,
  input  logic                   rst,
  input  logic                   dac_run,
  input  logic [15:0]            sample_div,
  input  logic [CHANNEL-1:0]     dac_pcm_out_valid,
  output logic [CHANNEL-1:0]     dac_pcm_out_ready,
  input  logic [16*CHANNEL-1:0]  dac_pcm_out,
  output logic                   spi_sclk,
  output logic                   spi_cs_n,
  output logic                   spi_mosi,
  output logic [15:0]            underrun_cnt,
  output logic                   tick_miss,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_TAIL, S_GAP
  } state_t;

  localparam logic [15:0] HALF_LAST = 16'(SCLK_HALF - 1);
  localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);
  localparam logic [3:0]  LAST_CH   = 4'(CHANNEL - 1);

  function automatic logic [4:0] count_missing(input logic [CHANNEL-1:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int k = 0; k < CHANNEL; k++) n = n + {4'd0, ~v[k]};
    return n;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [4:0] n);
    logic [16:0] s;
    s = {1'b0, a} + {12'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [23:0] make_frame(input logic [3:0] ch, input logic signed [15:0] s);
    logic [15:0] u;
    u = s;
    if (OFFSET_BIN) u[15] = ~u[15];
    return {DAC_CMD, ch, u};
  endfunction

  state_t             r_state;
  logic [15:0]        r_tcnt;
  logic [15:0]        r_ph;
  logic [4:0]         r_bit;
  logic [3:0]         r_ch;
  logic [22:0]        r_sr;
  logic               r_sclk, r_cs_n, r_mosi, r_miss;
  logic [15:0]        r_under;
  logic signed [15:0] r_hold [CHANNEL];

  logic [15:0]        w_period;
  logic               w_tick, w_pop, w_load, w_shift;
  logic [3:0]         w_ch_nxt;
  logic signed [15:0] w_s0, w_next_smp;
  logic [23:0]        w_frame;

  assign w_period = (sample_div < 16'd2) ? 16'd2 : sample_div;
  // >= rather than == so a runtime shrink of sample_div ticks at once and wraps
  assign w_tick   = dac_run && (r_tcnt >= w_period - 16'd1);
  assign w_pop    = w_tick && (r_state == S_IDLE);
  assign w_ch_nxt = r_ch + 4'd1;
  assign w_s0     = dac_pcm_out_valid[0] ? signed'(dac_pcm_out[15:0]) : r_hold[0];

  always_comb begin
    w_next_smp = r_hold[0];
    for (int k = 0; k < CHANNEL; k++)
      if (4'(k) == w_ch_nxt) w_next_smp = r_hold[k];
  end

  assign w_frame = (r_state == S_IDLE) ? make_frame(4'd0, w_s0) : make_frame(w_ch_nxt, w_next_smp);
  assign w_load  = w_pop ||
                   (r_state == S_GAP && r_ph == GAP_LAST && r_ch != LAST_CH);
  assign w_shift = (r_state == S_SHIFT_HI) && (r_ph == HALF_LAST) && (r_bit != 5'd0);

  assign dac_pcm_out_ready = w_pop ? dac_pcm_out_valid : '0;
  assign spi_sclk     = r_sclk;
  assign spi_cs_n     = r_cs_n;
  assign spi_mosi     = r_mosi;
  assign underrun_cnt = r_under;
  assign tick_miss    = r_miss;
  assign busy         = (r_state != S_IDLE);

  always_ff @(posedge pcm_clk) begin
    if (rst || !dac_run) r_tcnt <= 16'd0;
    else if (w_tick)     r_tcnt <= 16'd0;
    else                 r_tcnt <= r_tcnt + 16'd1;
  end

  // frame bits below the MSB; the MSB goes straight to mosi on load
  always_ff @(posedge pcm_clk) begin
    if (w_load)       r_sr <= w_frame[22:0];
    else if (w_shift) r_sr <= {r_sr[21:0], 1'b0};
  end

  always_ff @(posedge pcm_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sclk  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_mosi  <= 1'b0;
      r_ph    <= 16'd0;
      r_bit   <= 5'd0;
      r_ch    <= 4'd0;
      r_under <= 16'd0;
      r_miss  <= 1'b0;
      for (int k = 0; k < CHANNEL; k++) r_hold[k] <= 16'sd0;
    end else begin
      if (w_tick && r_state != S_IDLE) r_miss <= 1'b1;
      if (w_pop) begin
        for (int k = 0; k < CHANNEL; k++)
          if (dac_pcm_out_valid[k]) r_hold[k] <= signed'(dac_pcm_out[16*k +: 16]);
        r_under <= sat_add(r_under, count_missing(dac_pcm_out_valid));
      end
      if (w_load) begin
        r_state <= S_LOAD;
        r_cs_n  <= 1'b0;
        r_sclk  <= 1'b0;
        r_mosi  <= w_frame[23];
        r_ph    <= 16'd0;
        r_bit   <= 5'd23;
        r_ch    <= (r_state == S_IDLE) ? 4'd0 : w_ch_nxt;
      end else begin
        case (r_state)
          S_IDLE: ;
          S_LOAD, S_SHIFT_LO: begin
            if (r_ph == HALF_LAST) begin
              r_state <= S_SHIFT_HI;
              r_sclk  <= 1'b1;
              r_ph    <= 16'd0;
            end else begin
              r_state <= S_SHIFT_LO;
              r_ph    <= r_ph + 16'd1;
            end
          end
          S_SHIFT_HI: begin
            if (r_ph == HALF_LAST) begin
              r_sclk <= 1'b0;
              r_ph   <= 16'd0;
              if (r_bit == 5'd0) begin
                r_state <= S_TAIL;
              end else begin
                r_state <= S_SHIFT_LO;
                r_bit   <= r_bit - 5'd1;
                r_mosi  <= r_sr[22];
              end
            end else begin
              r_ph <= r_ph + 16'd1;
            end
          end
          S_TAIL: begin
            if (r_ph == HALF_LAST) begin
              r_state <= S_GAP;
              r_cs_n  <= 1'b1;
              r_mosi  <= 1'b0;
              r_ph    <= 16'd0;
            end else begin
              r_ph <= r_ph + 16'd1;
            end
          end
          S_GAP: begin
            if (r_ph == GAP_LAST) r_state <= S_IDLE;
            else                  r_ph    <= r_ph + 16'd1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
